// File: rtl/sweeper_pkg.sv
// sweeper_pkg: shared definitions for the truth-table sweeper family.
//   - sweep_state_e : sequencer state encoding
//   - NUM_VECTORS / VEC_W : input-vector count and width for a 3-input function
//   - EXPECTED_PARITY3 : truth table of odd parity over three inputs
//   - lowest_set / pop_count : helpers for reducing a mismatch mask
package sweeper_pkg;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;

    localparam logic [NUM_VECTORS-1:0] EXPECTED_PARITY3 = 8'h96;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StApply  = 2'd1,
        StSample = 2'd2,
        StFinish = 2'd3
    } sweep_state_e;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [VEC_W-1:0] lowest_set(input logic [NUM_VECTORS-1:0] v);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = VEC_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] pop_count(input logic [NUM_VECTORS-1:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// sweep_settle_timer: settle-interval counter for function sweepers.
// Counts up from 0 while enabled and stops at SETTLE_CYCLES-1, where it raises
// terminal. A SETTLE_CYCLES of 0 behaves as 1.
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high reset (count -> 0)
//   clear    : reload the count to 0
//   enable   : advance the count (saturates at the terminal value)
//   terminal : count has reached SETTLE_CYCLES-1
module sweep_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned EffCycles = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned CntW      = (EffCycles > 1) ? $clog2(EffCycles) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(EffCycles - 1);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !terminal) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign terminal = (count_q == LastCount);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 8 input vectors of an external 3-input function
// unit in ascending order, samples F for each after a settle interval, builds the
// truth table and compares it with EXPECTED.
// Optional build macro SWEEPER_ERRCNT_EN adds the ErrCount output.
// Ports:
//   Clock    : system clock, rising edge
//   Reset    : synchronous, active-high reset
//   Start    : sweep request, sampled only while idle
//   F        : function unit output (already synchronous)
//   X1/X2/X3 : function inputs, vector bits 2/1/0
//   Busy     : sweep in progress
//   Done     : one-cycle pulse at end of sweep
//   Pass     : Table == EXPECTED, valid from Done until next Start
//   Table    : captured truth table, bit i = F for vector i
//   FailIdx  : lowest mismatching vector index, 0 when Pass
//   ErrCount : number of mismatching bits (SWEEPER_ERRCNT_EN only)
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int unsigned            SETTLE_CYCLES = 1,
    parameter logic [NUM_VECTORS-1:0] EXPECTED      = EXPECTED_PARITY3
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   F,
    output logic                   X1,
    output logic                   X2,
    output logic                   X3,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Pass,
    output logic [NUM_VECTORS-1:0] Table,
    output logic [VEC_W-1:0]       FailIdx
`ifdef SWEEPER_ERRCNT_EN
    ,
    output logic [3:0]             ErrCount
`endif
);

    sweep_state_e           state_q, state_d;
    logic [VEC_W-1:0]       idx_q, idx_d;
    logic [NUM_VECTORS-1:0] table_q, table_d;
    logic [VEC_W-1:0]       fail_idx_q, fail_idx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [NUM_VECTORS-1:0] table_next;
    logic [NUM_VECTORS-1:0] mismatch;
    logic                   timer_clear;
    logic                   timer_enable;
    logic                   settled;
`ifdef SWEEPER_ERRCNT_EN
    logic [3:0]             err_cnt_q, err_cnt_d;
`endif

    sweep_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clock   (Clock),
        .reset   (Reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .terminal(settled)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        table_d      = table_q;
        fail_idx_d   = fail_idx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
`ifdef SWEEPER_ERRCNT_EN
        err_cnt_d    = err_cnt_q;
`endif
        // Table including the bit being sampled now, so the verdict registered
        // on the last sample already covers vector 7.
        table_next         = table_q;
        table_next[idx_q]  = F;
        mismatch           = table_next ^ EXPECTED;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    idx_d       = '0;
                    table_d     = '0;
                    pass_d      = 1'b0;
                    fail_idx_d  = '0;
                    busy_d      = 1'b1;
                    timer_clear = 1'b1;
`ifdef SWEEPER_ERRCNT_EN
                    err_cnt_d   = '0;
`endif
                    state_d     = StApply;
                end
            end
            StApply: begin
                timer_enable = 1'b1;
                if (settled) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                table_d = table_next;
                if (idx_q == VEC_W'(NUM_VECTORS - 1)) begin
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    pass_d     = (mismatch == '0);
                    fail_idx_d = lowest_set(mismatch);
`ifdef SWEEPER_ERRCNT_EN
                    err_cnt_d  = pop_count(mismatch);
`endif
                    state_d    = StFinish;
                end else begin
                    idx_d       = idx_q + 1'b1;
                    timer_clear = 1'b1;
                    state_d     = StApply;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            table_q    <= '0;
            fail_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef SWEEPER_ERRCNT_EN
            err_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            table_q    <= table_d;
            fail_idx_q <= fail_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
`ifdef SWEEPER_ERRCNT_EN
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    assign {X1, X2, X3} = idx_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Pass         = pass_q;
    assign Table        = table_q;
    assign FailIdx      = fail_idx_q;
`ifdef SWEEPER_ERRCNT_EN
    assign ErrCount     = err_cnt_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper. Three instances share the clock:
//   0: SETTLE_CYCLES=1, 1: SETTLE_CYCLES=3, 2: SETTLE_CYCLES=0.
// Each instance's function unit is a lookup table indexed by {X1,X2,X3}.
module tb_truth_table_sweeper;

    localparam logic [7:0] EXP_MASK = 8'h96;

    logic       clk;
    logic       rst      [3];
    logic       start    [3];
    logic       f        [3];
    logic       x1       [3];
    logic       x2       [3];
    logic       x3       [3];
    logic       busy     [3];
    logic       done     [3];
    logic       pass     [3];
    logic [7:0] tbl      [3];
    logic [2:0] fail_idx [3];
    logic [3:0] err_cnt  [3];
    logic [7:0] f_lut    [3];

    int passed = 0;
    int total  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign f[g] = f_lut[g][{x1[g], x2[g], x3[g]}];
        truth_table_sweeper #(
            .SETTLE_CYCLES((g == 1) ? 3 : ((g == 2) ? 0 : 1))
        ) dut (
            .Clock   (clk),
            .Reset   (rst[g]),
            .Start   (start[g]),
            .F       (f[g]),
            .X1      (x1[g]),
            .X2      (x2[g]),
            .X3      (x3[g]),
            .Busy    (busy[g]),
            .Done    (done[g]),
            .Pass    (pass[g]),
            .Table   (tbl[g]),
            .FailIdx (fail_idx[g])
`ifdef SWEEPER_ERRCNT_EN
            ,
            .ErrCount(err_cnt[g])
`endif
        );
`ifndef SWEEPER_ERRCNT_EN
        assign err_cnt[g] = 4'd0;
`endif
    end

    function automatic int eff_settle(input int u);
        return (u == 1) ? 3 : 1;
    endfunction

    function automatic logic [7:0] parity_lut();
        logic [7:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i] = ^(3'(i));
        end
        return l;
    endfunction

    // Full sweep on instance u with the function unit given by lut; checks
    // every cycle's vector/Busy/Done and the final verdict.
    task automatic run_sweep(input int u, input logic [7:0] lut, input string name);
        int         per;
        int         tdone;
        logic [2:0] exp_x;
        logic [2:0] exp_fi;
        logic [7:0] expm;
        logic       exp_pass;
        bit         found;
        per   = eff_settle(u) + 1;
        tdone = 8 * per + 1;
        expm  = EXP_MASK;
        exp_pass = (lut == expm);
        exp_fi = 3'd0;
        found  = 0;
        for (int i = 0; i < 8; i++) begin
            if (!found && lut[i] != expm[i]) begin
                exp_fi = 3'(i);
                found  = 1;
            end
        end
        f_lut[u] = lut;
        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        for (int c = 1; c < tdone; c++) begin
            exp_x = 3'((c - 1) / per);
            total++;
            if ({x1[u], x2[u], x3[u], busy[u], done[u]} !== {exp_x, 2'b10})
                $display("FAIL %s step c%0d: x=%0d busy=%b done=%b, want x=%0d busy=1 done=0",
                         name, c, {x1[u], x2[u], x3[u]}, busy[u], done[u], exp_x);
            else passed++;
            @(negedge clk);
        end
        total++;
        if ({done[u], busy[u]} !== 2'b10)
            $display("FAIL %s done_timing: done=%b busy=%b at cycle %0d, want done=1 busy=0",
                     name, done[u], busy[u], tdone);
        else passed++;
        total++;
        if (tbl[u] !== lut || pass[u] !== exp_pass || fail_idx[u] !== exp_fi)
            $display("FAIL %s result: table=%h pass=%b fidx=%0d, want table=%h pass=%b fidx=%0d",
                     name, tbl[u], pass[u], fail_idx[u], lut, exp_pass, exp_fi);
        else passed++;
`ifdef SWEEPER_ERRCNT_EN
        total++;
        if (err_cnt[u] !== 4'($countones(lut ^ expm)))
            $display("FAIL %s errcount: got %0d want %0d", name, err_cnt[u],
                     $countones(lut ^ expm));
        else passed++;
`endif
        @(negedge clk);
        total++;
        if (done[u] !== 1'b0 || busy[u] !== 1'b0 || tbl[u] !== lut || pass[u] !== exp_pass
            || {x1[u], x2[u], x3[u]} !== 3'd7)
            $display("FAIL %s hold: done=%b busy=%b table=%h pass=%b x=%0d, want 0 0 %h %b 7",
                     name, done[u], busy[u], tbl[u], pass[u], {x1[u], x2[u], x3[u]},
                     lut, exp_pass);
        else passed++;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) begin
            rst[u]   = 1'b1;
            start[u] = 1'b0;
            f_lut[u] = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            total++;
            if ({x1[u], x2[u], x3[u], busy[u], done[u], pass[u], tbl[u], fail_idx[u],
                 err_cnt[u]} !== '0)
                $display("FAIL reset_state[%0d]: x=%0d busy=%b done=%b pass=%b table=%h fidx=%0d",
                         u, {x1[u], x2[u], x3[u]}, busy[u], done[u], pass[u], tbl[u],
                         fail_idx[u]);
            else passed++;
            rst[u] = 1'b0;
        end
    endtask

    task automatic test_patterns();
        run_sweep(0, parity_lut(), "parity");
        run_sweep(0, 8'h00, "stuck0");
        run_sweep(0, 8'h80, "and3");
        for (int n = 0; n < 4; n++) begin
            run_sweep(0, 8'($urandom), "random");
        end
    endtask

    task automatic test_settle();
        run_sweep(1, parity_lut(), "settle3_parity");
        run_sweep(1, 8'($urandom), "settle3_random");
        run_sweep(2, parity_lut(), "settle0_parity");
        run_sweep(2, 8'($urandom), "settle0_random");
    endtask

    task automatic test_start_ignored();
        int dones;
        f_lut[0] = parity_lut();
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        dones = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done[0] === 1'b1) dones++;
            start[0] = (c == 5 || c == 17 || c == 20);
            @(negedge clk);
        end
        start[0] = 1'b0;
        total++;
        if (dones != 1) $display("FAIL ignore_start dones: got %0d want 1", dones);
        else passed++;
        total++;
        if (busy[0] !== 1'b1 || tbl[0] !== 8'h00 || pass[0] !== 1'b0)
            $display("FAIL ignore_start restart: busy=%b table=%h pass=%b, want 1 00 0",
                     busy[0], tbl[0], pass[0]);
        else passed++;
        repeat (16) @(negedge clk);
        total++;
        if (done[0] !== 1'b1 || tbl[0] !== parity_lut() || pass[0] !== 1'b1)
            $display("FAIL ignore_start second: done=%b table=%h pass=%b, want 1 96 1",
                     done[0], tbl[0], pass[0]);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        f_lut[0] = parity_lut();
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        repeat (17) @(negedge clk);
        // cycle 18: idle, Start sampled here
        total++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || pass[0] !== 1'b1)
            $display("FAIL b2b idle: busy=%b done=%b pass=%b, want 0 0 1",
                     busy[0], done[0], pass[0]);
        else passed++;
        @(negedge clk);
        start[0] = 1'b0;
        total++;
        if (busy[0] !== 1'b1 || tbl[0] !== 8'h00)
            $display("FAIL b2b restart: busy=%b table=%h, want 1 00", busy[0], tbl[0]);
        else passed++;
        repeat (16) @(negedge clk);
        total++;
        if (done[0] !== 1'b1 || pass[0] !== 1'b1)
            $display("FAIL b2b second: done=%b pass=%b, want 1 1", done[0], pass[0]);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dones;
        f_lut[0] = parity_lut();
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        total++;
        if ({x1[0], x2[0], x3[0], busy[0], done[0], pass[0], tbl[0], fail_idx[0],
             err_cnt[0]} !== '0)
            $display("FAIL reset_mid: x=%0d busy=%b done=%b pass=%b table=%h fidx=%0d, want 0",
                     {x1[0], x2[0], x3[0]}, busy[0], done[0], pass[0], tbl[0], fail_idx[0]);
        else passed++;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) dones++;
            @(negedge clk);
        end
        total++;
        if (dones != 0) $display("FAIL reset_mid quiet: %0d active cycles, want 0", dones);
        else passed++;
        run_sweep(0, parity_lut(), "after_reset");
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_settle();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
